fpga_top: RTL and testbench
===========================

FPGA_TOP -- requirements
Module: fpga_top

Interface
REQ-001 SHALL have localparam CFG_BITS, 66, length of the configuration chain (not overridable).
REQ-002 SHALL have port clk, input, 1, single rising-edge clock for the configuration chain and the cell flip-flops.
REQ-003 SHALL have port global_reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port prog_en, input, 1, configuration shift enable.
REQ-005 SHALL have port ccff_head, input, 1, serial configuration data in.
REQ-006 SHALL have port ccff_tail, output, 1, serial configuration data out, equal to cfg[65].
REQ-007 SHALL have port pad_in, input, 8, user input pads.
REQ-008 SHALL have port pad_out, output, 4, user output pads.

Function
REQ-009 SHALL hold configuration register cfg[65:0]; when prog_en=1, each clk edge shifts cfg <= {cfg[64:0], ccff_head}; when prog_en=0, cfg holds.
REQ-010 SHALL implement two logic cells, k=0,1, with base offset B=29*k.
REQ-011 Cell fields SHALL be: LUT truth table cfg[B+15:B]; input selects sel0=cfg[B+18:B+16], sel1=cfg[B+21:B+19], sel2=cfg[B+24:B+22], sel3=cfg[B+27:B+25]; registered-mode bit cfg[B+28].
REQ-012 Cell input i_n SHALL be pad_in[sel_n]; LUT output SHALL be truth[{i3,i2,i1,i0}], with i0 as the LSB of the index.
REQ-013 Cell output SHALL be the LUT output combinationally when registered-mode=0, otherwise the cell flip-flop.
REQ-014 Cell flip-flop SHALL capture the LUT output on each rising clk while prog_en=0, giving exactly 1-cycle latency.
REQ-015 Output pad j (j=0..3) SHALL select via cfg[59+2j:58+2j]: 00 -> 0, 01 -> cell0, 10 -> cell1, 11 -> 1.
REQ-016 While prog_en=1, pad_out SHALL be forced to 4'b0000 and both cell flip-flops SHALL be cleared synchronously.
REQ-017 The pad_in -> pad_out path in combinational mode SHALL contain no storage; pad_out SHALL follow pad_in within the same cycle.
REQ-018 ccff_tail SHALL be a direct register output, so that a bit entering ccff_head appears on ccff_tail after exactly 66 shift cycles.

Reset
REQ-019 global_reset=1 SHALL immediately clear cfg and both cell flip-flops to 0, independent of clk.
REQ-020 During and after reset: pad_out=0000, ccff_tail=0.
REQ-021 Reset asserted mid-shift SHALL discard the partial configuration; after reset release, shifting restarts from all-zero contents.
REQ-022 Reset release SHALL be usable on any cycle; the first clk edge after release SHALL behave normally.

Configuration
REQ-023 With macro FPGA_CFG_LOCK_EN defined, the block SHALL add input port cfg_lock (1 bit).
REQ-024 With FPGA_CFG_LOCK_EN defined and cfg_lock=1, prog_en SHALL be treated as 0: no shifting, no output forcing, cell flip-flops run normally.
REQ-025 Without FPGA_CFG_LOCK_EN, the block SHALL have no cfg_lock port and prog_en SHALL act as specified above.

Verification
REQ-026 Load XOR config (cell0 truth=16'h6666, sel0=0, sel1=1, combinational; pad0 sel=01, all else 0) via 66 shifts, prog_en=0; then (pad_in[0],pad_in[1]) = 00,01,10,11 -> pad_out[0] = 0,1,1,0.
REQ-027 Same config with cell0 registered-mode=1; apply a=1, b=0 -> pad_out[0] stays 0 until the next clk edge, then becomes 1.
REQ-028 Shift a single 1 followed by 0s -> ccff_tail goes 1 on exactly the 66th edge after that 1 was sampled, then returns to 0.
REQ-029 Assert global_reset asynchronously after 30 of 66 shifts -> pad_out=0000 and ccff_tail=0 at once; a full reload afterwards restores XOR behaviour.
REQ-030 XOR config loaded, then raise prog_en for 1 cycle -> pad_out=0000 while prog_en=1; config shifted by one position.
REQ-031 With FPGA_CFG_LOCK_EN defined: cfg_lock=1, toggle prog_en -> ccff_tail unchanged and XOR outputs continue.

Source files
------------

// File: rtl/fpga_top.sv
// fpga_top: a small FPGA fabric built from a 66-bit serial configuration chain,
// two 4-input LUT cells (each with an optional output flip-flop), and four
// output pads that each pick a constant or a cell output.
//
// Configuration chain layout (cell base B = 29*k, k = 0..1):
//   cfg[B+15:B]    LUT truth table
//   cfg[B+18:B+16] sel0, cfg[B+21:B+19] sel1, cfg[B+24:B+22] sel2, cfg[B+27:B+25] sel3
//   cfg[B+28]      registered mode
//   cfg[59+2j:58+2j] output pad j select: 00 -> 0, 01 -> cell0, 10 -> cell1, 11 -> 1
//
// Ports:
//   clk          rising-edge clock for the chain and the cell flip-flops
//   global_reset asynchronous active-high reset
//   prog_en      configuration shift enable (forces pad_out to 0 while high)
//   ccff_head    serial configuration input
//   ccff_tail    serial configuration output (cfg[65])
//   pad_in[7:0]  user input pads
//   pad_out[3:0] user output pads
//   cfg_lock     only with FPGA_CFG_LOCK_EN defined; when high, prog_en is ignored
//
// Optional feature macro: FPGA_CFG_LOCK_EN
module fpga_top (
  input  logic       clk,
  input  logic       global_reset,
  input  logic       prog_en,
  input  logic       ccff_head,
`ifdef FPGA_CFG_LOCK_EN
  input  logic       cfg_lock,
`endif
  output logic       ccff_tail,
  input  logic [7:0] pad_in,
  output logic [3:0] pad_out
);

  localparam int CFG_BITS = 66;

  logic [CFG_BITS-1:0] cfg;
  logic [1:0]          lut;
  logic [1:0]          cell_q;
  logic [1:0]          cell_out;
  logic                prog;

`ifdef FPGA_CFG_LOCK_EN
  assign prog = prog_en & ~cfg_lock;
`else
  assign prog = prog_en;
`endif

  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      cfg <= '0;
    end else if (prog) begin
      cfg <= {cfg[CFG_BITS-2:0], ccff_head};
    end
  end

  // The tail is taken straight from the last chain flop.
  assign ccff_tail = cfg[CFG_BITS-1];

  for (genvar k = 0; k < 2; k++) begin : g_cell
    localparam int B = 29 * k;
    logic [15:0] truth;
    logic [3:0]  idx;
    assign truth = cfg[B+15:B];
    // i0 is the LSB of the truth table index.
    assign idx = {pad_in[cfg[B+27:B+25]], pad_in[cfg[B+24:B+22]],
                  pad_in[cfg[B+21:B+19]], pad_in[cfg[B+18:B+16]]};
    assign lut[k]      = truth[idx];
    assign cell_out[k] = cfg[B+28] ? cell_q[k] : lut[k];
  end

  // Cell flops are cleared while programming so a fresh configuration
  // never starts with stale registered values.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      cell_q <= '0;
    end else if (prog) begin
      cell_q <= '0;
    end else begin
      cell_q <= lut;
    end
  end

  always_comb begin
    pad_out = '0;
    if (!prog) begin
      for (int j = 0; j < 4; j++) begin
        case (cfg[58+2*j +: 2])
          2'b00:   pad_out[j] = 1'b0;
          2'b01:   pad_out[j] = cell_out[0];
          2'b10:   pad_out[j] = cell_out[1];
          default: pad_out[j] = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpga_top.sv
module tb_fpga_top;

  logic       clk;
  logic       global_reset;
  logic       prog_en;
  logic       ccff_head;
  logic       ccff_tail;
  logic [7:0] pad_in;
  logic [3:0] pad_out;
`ifdef FPGA_CFG_LOCK_EN
  logic       cfg_lock;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [65:0] cfg_xor;
  logic [65:0] cfg_xor_reg;
  logic [65:0] cfg_mix;

  fpga_top dut (
    .clk(clk),
    .global_reset(global_reset),
    .prog_en(prog_en),
    .ccff_head(ccff_head),
`ifdef FPGA_CFG_LOCK_EN
    .cfg_lock(cfg_lock),
`endif
    .ccff_tail(ccff_tail),
    .pad_in(pad_in),
    .pad_out(pad_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // Shifts v in MSB first so that v[i] ends up in cfg[i].
  // Returns at a falling edge with prog_en low.
  task automatic load_cfg(input logic [65:0] v);
    for (int i = 65; i >= 0; i--) begin
      @(negedge clk);
      prog_en   = 1'b1;
      ccff_head = v[i];
    end
    @(negedge clk);
    prog_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  initial begin
    // XOR of pad_in[0], pad_in[1] on cell0, routed to pad0.
    cfg_xor          = '0;
    cfg_xor[15:0]    = 16'h6666;
    cfg_xor[18:16]   = 3'd0;
    cfg_xor[21:19]   = 3'd1;
    cfg_xor[59:58]   = 2'b01;
    cfg_xor_reg      = cfg_xor;
    cfg_xor_reg[28]  = 1'b1;
    // cell0 = buffer of pad_in[2] -> pad0; cell1 = pad_in[6] & pad_in[7] -> pad1;
    // pad2 = 0; pad3 = 1.
    cfg_mix          = '0;
    cfg_mix[15:0]    = 16'hAAAA;
    cfg_mix[18:16]   = 3'd2;
    cfg_mix[44:29]   = 16'h8888;
    cfg_mix[47:45]   = 3'd6;
    cfg_mix[50:48]   = 3'd7;
    cfg_mix[59:58]   = 2'b01;
    cfg_mix[61:60]   = 2'b10;
    cfg_mix[63:62]   = 2'b00;
    cfg_mix[65:64]   = 2'b11;

    global_reset = 1'b1;
    prog_en      = 1'b0;
    ccff_head    = 1'b0;
    pad_in       = 8'h00;
`ifdef FPGA_CFG_LOCK_EN
    cfg_lock     = 1'b0;
`endif
    #12;
    chk("reset_pad", pad_out, 4'b0000);
    chk("reset_tail", {3'b0, ccff_tail}, 4'b0000);
    @(negedge clk);
    global_reset = 1'b0;
    @(negedge clk);
    chk("post_reset_pad", pad_out, 4'b0000);

    // Combinational XOR truth table.
    load_cfg(cfg_xor);
    pad_in = 8'b00; #1 chk("xor_00", {3'b0, pad_out[0]}, 4'b0000);
    pad_in = 8'b10; #1 chk("xor_01", {3'b0, pad_out[0]}, 4'b0001);
    pad_in = 8'b01; #1 chk("xor_10", {3'b0, pad_out[0]}, 4'b0001);
    pad_in = 8'b11; #1 chk("xor_11", {3'b0, pad_out[0]}, 4'b0000);
    chk("xor_tail", {3'b0, ccff_tail}, 4'b0000);

    // Registered XOR: one cycle of latency.
    pad_in = 8'h00;
    load_cfg(cfg_xor_reg);
    pad_in = 8'b01;
    #1 chk("reg_before_edge", pad_out, 4'b0000);
    @(negedge clk);
    chk("reg_after_edge", pad_out, 4'b0001);
    pad_in = 8'b11;
    #1 chk("reg_hold", pad_out, 4'b0001);
    @(negedge clk);
    chk("reg_update", pad_out, 4'b0000);

    // Both cells, constants and cell1 routing.
    load_cfg(cfg_mix);
    pad_in = 8'b1100_0100; #1 chk("mix_a", pad_out, 4'b1011);
    pad_in = 8'b0100_0000; #1 chk("mix_b", pad_out, 4'b1000);
    pad_in = 8'b1000_0100; #1 chk("mix_c", pad_out, 4'b1001);
    chk("mix_tail", {3'b0, ccff_tail}, 4'b0001);

`ifdef FPGA_CFG_LOCK_EN
    // Locked: prog_en is ignored.
    @(negedge clk);
    cfg_lock = 1'b1;
    prog_en  = 1'b1;
    pad_in   = 8'b1100_0100;
    #1 chk("lock_pad", pad_out, 4'b1011);
    repeat (3) @(negedge clk);
    chk("lock_tail", {3'b0, ccff_tail}, 4'b0001);
    chk("lock_pad2", pad_out, 4'b1011);
    prog_en  = 1'b0;
    cfg_lock = 1'b0;
`endif

    // Async reset with a live configuration.
    load_cfg(cfg_xor);
    pad_in = 8'b01;
    #1 chk("pre_reset_xor", pad_out, 4'b0001);
    #2 global_reset = 1'b1;
    #1 chk("async_reset_pad", pad_out, 4'b0000);
    @(negedge clk);
    global_reset = 1'b0;
    #1 chk("cleared_cfg_pad", pad_out, 4'b0000);

    // Single 1 through the chain (cfg all zero after reset).
    @(negedge clk);
    prog_en   = 1'b1;
    ccff_head = 1'b1;
    @(negedge clk);
    ccff_head = 1'b0;
    repeat (64) @(negedge clk);
    chk("tail_edge65", {3'b0, ccff_tail}, 4'b0000);
    @(negedge clk);
    chk("tail_edge66", {3'b0, ccff_tail}, 4'b0001);
    @(negedge clk);
    chk("tail_edge67", {3'b0, ccff_tail}, 4'b0000);
    prog_en = 1'b0;

    // Mid-shift reset: 30 of 66 bits, then reset and full reload.
    for (int i = 65; i >= 36; i--) begin
      @(negedge clk);
      prog_en   = 1'b1;
      ccff_head = cfg_xor[i];
    end
    @(negedge clk);
    #2 global_reset = 1'b1;
    #1 chk("midshift_reset_pad", pad_out, 4'b0000);
    chk("midshift_reset_tail", {3'b0, ccff_tail}, 4'b0000);
    prog_en = 1'b0;
    @(negedge clk);
    global_reset = 1'b0;
    load_cfg(cfg_xor);
    pad_in = 8'b10; #1 chk("reload_xor_01", pad_out, 4'b0001);
    pad_in = 8'b11; #1 chk("reload_xor_11", pad_out, 4'b0000);

    // One extra shift: outputs forced low, cfg moves up one place.
    // The pad0 select bit (cfg[58]) lands in cfg[59], then needs six more shifts to reach the tail.
    pad_in = 8'b01;
    #1 chk("xor_before_prog", pad_out, 4'b0001);
    @(negedge clk);
    prog_en   = 1'b1;
    ccff_head = 1'b0;
    #1 chk("prog_force", pad_out, 4'b0000);
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("shift1_tail_5", {3'b0, ccff_tail}, 4'b0000);
    @(negedge clk);
    chk("shift1_tail_6", {3'b0, ccff_tail}, 4'b0001);
    chk("prog_force2", pad_out, 4'b0000);
    prog_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
